leaf_router: RTL and testbench



---
 rtl/leaf_router_if.sv | 29 ++
 rtl/leaf_router.sv | 171 +++++++++++++++++
 tb/tb_leaf_router.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/leaf_router_if.sv
// rtl/leaf_router_if.sv - flit ports between the leaf router, its four NIs and the uplink
interface leaf_router_if #(
  parameter int DATA_W = 16
);
  logic [4*DATA_W-1:0] loc_data_in;
  logic [3:0]          loc_valid_in;
  logic [3:0]          loc_ready_out;
  logic [4*DATA_W-1:0] loc_data_out;
  logic [3:0]          loc_valid_out;
  logic [DATA_W-1:0]   up_data_in;
  logic                up_valid_in;
  logic                up_ready_out;
  logic [DATA_W-1:0]   up_data_out;
  logic                up_valid_out;
  logic                up_ready_in;
  logic [7:0]          drop_count;

  modport slave (
    input  loc_data_in, loc_valid_in, up_data_in, up_valid_in, up_ready_in,
    output loc_ready_out, loc_data_out, loc_valid_out,
    output up_ready_out, up_data_out, up_valid_out, drop_count
  );

  modport master (
    output loc_data_in, loc_valid_in, up_data_in, up_valid_in, up_ready_in,
    input  loc_ready_out, loc_data_out, loc_valid_out,
    input  up_ready_out, up_data_out, up_valid_out, drop_count
  );
endinterface

// File: rtl/leaf_router.sv
// rtl/leaf_router.sv - leaf switch: 4 NI ports + uplink, per-input FIFOs, per-output round-robin
module leaf_router #(
  parameter logic [3:0] GROUP_ID   = 4'd6,
  parameter int         DATA_W     = 16,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  leaf_router_if.slave bus
);
  localparam int NIN = 5;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [CW-1:0] FULL   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ALMOST = CW'(FIFO_DEPTH - 1);

  logic [DATA_W-1:0] mem [NIN][FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr [NIN];
  logic [PW-1:0]     rd_ptr [NIN];
  logic [CW-1:0]     count  [NIN];

  logic [DATA_W-1:0] in_data [NIN];
  logic [NIN-1:0]    in_valid;
  logic [NIN-1:0]    wr_en;
  logic [NIN-1:0]    drop;
  logic [NIN-1:0]    pop;
  logic [NIN-1:0]    nonempty;
  logic [DATA_W-1:0] head [NIN];
  logic [2:0]        dest [NIN];
  logic              up_ready;

  logic [2:0]        last_loc [4];
  logic [1:0]        last_up;
  logic [4:0]        gnt_valid;
  logic [2:0]        gnt_src [5];
  logic              up_arb_en;
  logic [3:0]        tmp;

  logic [DATA_W-1:0] loc_data_q [4];
  logic [3:0]        loc_valid_q;
  logic [DATA_W-1:0] up_data_q;
  logic              up_valid_q;
  logic [7:0]        drop_cnt;
  logic [8:0]        drop_sum;
  logic [7:0]        drop_next;

  // Ingress: local ports may also write a full FIFO whose head leaves on the same edge
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      in_data[k]  = bus.loc_data_in[k*DATA_W +: DATA_W];
      in_valid[k] = bus.loc_valid_in[k];
      wr_en[k]    = in_valid[k] && ((count[k] < FULL) || pop[k]);
      drop[k]     = in_valid[k] && !wr_en[k];
    end
    in_data[4]  = bus.up_data_in;
    in_valid[4] = bus.up_valid_in;
    up_ready    = count[4] < FULL;
    wr_en[4]    = in_valid[4] && up_ready && (in_data[4][DATA_W-1 -: 4] == GROUP_ID);
    drop[4]     = in_valid[4] && up_ready && (in_data[4][DATA_W-1 -: 4] != GROUP_ID);
  end

  always_comb begin
    for (int k = 0; k < NIN; k++) begin
      head[k]     = mem[k][rd_ptr[k]];
      nonempty[k] = count[k] != '0;
      dest[k]     = (head[k][DATA_W-1 -: 4] == GROUP_ID) ? {1'b0, head[k][DATA_W-5 -: 2]} : 3'd4;
    end
  end

  // Round-robin search starts one past the last winner of each output
  always_comb begin
    pop       = '0;
    gnt_valid = '0;
    tmp       = '0;
    for (int j = 0; j < 5; j++) gnt_src[j] = '0;
    up_arb_en = !up_valid_q || bus.up_ready_in;
    for (int j = 0; j < 4; j++) begin
      for (int i = 1; i <= NIN; i++) begin
        tmp = 4'(last_loc[j]) + 4'(i);
        if (tmp >= 4'(NIN)) tmp = tmp - 4'(NIN);
        if (!gnt_valid[j] && nonempty[tmp[2:0]] && dest[tmp[2:0]] == 3'(j)) begin
          gnt_valid[j] = 1'b1;
          gnt_src[j]   = tmp[2:0];
        end
      end
    end
    if (up_arb_en) begin
      for (int i = 1; i <= 4; i++) begin
        tmp = {2'b00, last_up} + 4'(i);
        if (tmp >= 4'd4) tmp = tmp - 4'd4;
        if (!gnt_valid[4] && nonempty[tmp[2:0]] && dest[tmp[2:0]] == 3'd4) begin
          gnt_valid[4] = 1'b1;
          gnt_src[4]   = tmp[2:0];
        end
      end
    end
    for (int j = 0; j < 5; j++)
      if (gnt_valid[j]) pop[gnt_src[j]] = 1'b1;
  end

  always_comb begin
    drop_sum = {1'b0, drop_cnt};
    for (int k = 0; k < NIN; k++) drop_sum = drop_sum + 9'(drop[k]);
    drop_next = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NIN; k++)
      if (wr_en[k]) mem[k][wr_ptr[k]] <= in_data[k];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NIN; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NIN; k++) begin
        if (wr_en[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
        if (pop[k])   rd_ptr[k] <= rd_ptr[k] + 1'b1;
        count[k] <= count[k] + CW'(wr_en[k]) - CW'(pop[k]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < 4; j++) begin
        loc_data_q[j] <= '0;
        last_loc[j]   <= '0;
      end
      loc_valid_q <= '0;
      up_data_q   <= '0;
      up_valid_q  <= 1'b0;
      last_up     <= '0;
      drop_cnt    <= '0;
    end else begin
      for (int j = 0; j < 4; j++) begin
        loc_valid_q[j] <= gnt_valid[j];
        if (gnt_valid[j]) begin
          loc_data_q[j] <= head[gnt_src[j]];
          last_loc[j]   <= gnt_src[j];
        end
      end
      if (up_arb_en) begin
        up_valid_q <= gnt_valid[4];
        if (gnt_valid[4]) begin
          up_data_q <= head[gnt_src[4]];
          last_up   <= gnt_src[4][1:0];
        end
      end
      drop_cnt <= drop_next;
    end
  end

  always_comb begin
    bus.loc_data_out = '0;
    for (int j = 0; j < 4; j++) begin
      bus.loc_data_out[j*DATA_W +: DATA_W] = loc_data_q[j];
      bus.loc_ready_out[j] = count[j] < ALMOST;
    end
  end

  assign bus.loc_valid_out = loc_valid_q;
  assign bus.up_ready_out  = up_ready;
  assign bus.up_data_out   = up_data_q;
  assign bus.up_valid_out  = up_valid_q;
  assign bus.drop_count    = drop_cnt;
endmodule

// File: tb/tb_leaf_router.sv
// tb/tb_leaf_router.sv - directed self-checking bench for leaf_router
module tb_leaf_router;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  leaf_router_if #(.DATA_W(16)) bus ();

  leaf_router #(.GROUP_ID(4'd6), .DATA_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int exp_drops = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.loc_data_in  = '0;
    bus.loc_valid_in = '0;
    bus.up_data_in   = '0;
    bus.up_valid_in  = 1'b0;
    bus.up_ready_in  = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
    step();
    tests_run++;
    if (bus.loc_valid_out !== 4'h0 || bus.up_valid_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valids: got loc=%h up=%b expected 0/0", bus.loc_valid_out, bus.up_valid_out);
    end
    tests_run++;
    if (bus.loc_data_out !== 64'h0 || bus.up_data_out !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got loc=%h up=%h expected 0", bus.loc_data_out, bus.up_data_out);
    end
    tests_run++;
    if (bus.drop_count !== 8'd0 || bus.loc_ready_out !== 4'hF || bus.up_ready_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_status: got drop=%0d lrdy=%h urdy=%b expected 0/f/1",
               bus.drop_count, bus.loc_ready_out, bus.up_ready_out);
    end
  endtask

  task automatic test_local_route();
    bus.loc_data_in[15:0] = 16'h6455;
    bus.loc_valid_in = 4'b0001;
    step();
    bus.loc_valid_in = 4'b0000;
    tests_run++;
    if (bus.loc_valid_out !== 4'h0 || bus.up_valid_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL local_early: got loc=%h up=%b expected 0/0", bus.loc_valid_out, bus.up_valid_out);
    end
    step();
    tests_run++;
    if (bus.loc_valid_out !== 4'b0010 || bus.loc_data_out[31:16] !== 16'h6455 || bus.up_valid_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL local_pulse: got loc=%h data=%h up=%b expected 2/6455/0",
               bus.loc_valid_out, bus.loc_data_out[31:16], bus.up_valid_out);
    end
    step();
    tests_run++;
    if (bus.loc_valid_out !== 4'h0 || bus.loc_data_out[31:16] !== 16'h6455) begin
      tests_failed++;
      $display("FAIL local_hold: got loc=%h data=%h expected 0/6455", bus.loc_valid_out, bus.loc_data_out[31:16]);
    end
  endtask

  task automatic test_uplink_backpressure();
    bus.up_ready_in = 1'b0;
    bus.loc_data_in[47:32] = 16'h1C01;
    bus.loc_valid_in = 4'b0100;
    step();
    bus.loc_valid_in = 4'b0000;
    step();
    for (int c = 0; c < 6; c++) begin
      tests_run++;
      if (bus.up_valid_out !== 1'b1 || bus.up_data_out !== 16'h1C01 || bus.loc_valid_out !== 4'h0) begin
        tests_failed++;
        $display("FAIL uplink_stall[%0d]: got v=%b d=%h loc=%h expected 1/1c01/0",
                 c, bus.up_valid_out, bus.up_data_out, bus.loc_valid_out);
      end
      if (c < 5) step();
    end
    bus.up_ready_in = 1'b1;
    step();
    tests_run++;
    if (bus.up_valid_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL uplink_release: got v=%b expected 0", bus.up_valid_out);
    end
  endtask

  task automatic test_contention();
    int order [4];
    logic [15:0] exp_d;
    int src;
    order[0] = 2; order[1] = 3; order[2] = 4; order[3] = 0;
    for (int c = 0; c < 13; c++) begin
      if (c < 3) begin
        bus.loc_data_in[15:0]  = 16'h6C00 | 16'(c);
        bus.loc_data_in[47:32] = 16'h6C20 | 16'(c);
        bus.loc_data_in[63:48] = 16'h6C30 | 16'(c);
        bus.up_data_in         = 16'h6C40 | 16'(c);
        bus.loc_valid_in = 4'b1101;
        bus.up_valid_in  = 1'b1;
      end else begin
        bus.loc_valid_in = 4'b0000;
        bus.up_valid_in  = 1'b0;
      end
      step();
      if (c >= 1) begin
        src = order[(c-1) % 4];
        exp_d = 16'h6C00 | 16'(src << 4) | 16'((c-1) / 4);
        tests_run++;
        if (bus.loc_valid_out !== 4'b1000 || bus.loc_data_out[63:48] !== exp_d || bus.up_valid_out !== 1'b0) begin
          tests_failed++;
          $display("FAIL contention[%0d]: got loc=%h d=%h up=%b expected 8/%h/0",
                   c-1, bus.loc_valid_out, bus.loc_data_out[63:48], bus.up_valid_out, exp_d);
        end
      end
    end
    step();
    tests_run++;
    if (bus.loc_valid_out !== 4'h0) begin
      tests_failed++;
      $display("FAIL contention_end: got loc=%h expected 0", bus.loc_valid_out);
    end
  endtask

  task automatic test_flow_control();
    bus.up_ready_in = 1'b0;
    bus.loc_data_in[15:0] = 16'h1000;
    bus.loc_valid_in = 4'b0001;
    step();
    bus.loc_valid_in = 4'b0000;
    step();
    tests_run++;
    if (bus.up_valid_out !== 1'b1 || bus.up_data_out !== 16'h1000) begin
      tests_failed++;
      $display("FAIL fc_block: got v=%b d=%h expected 1/1000", bus.up_valid_out, bus.up_data_out);
    end
    for (int n = 1; n <= 4; n++) begin
      bus.loc_data_in[31:16] = 16'h1100 | 16'(n);
      bus.loc_valid_in = 4'b0010;
      step();
      tests_run++;
      if (bus.loc_ready_out[1] !== (n < 3)) begin
        tests_failed++;
        $display("FAIL fc_ready[%0d]: got %b expected %b", n, bus.loc_ready_out[1], (n < 3));
      end
    end
    bus.loc_data_in[31:16] = 16'h1105;
    step();
    bus.loc_valid_in = 4'b0000;
    exp_drops++;
    tests_run++;
    if (bus.drop_count !== 8'(exp_drops) || bus.loc_ready_out[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL fc_drop: got drop=%0d rdy=%b expected %0d/0", bus.drop_count, bus.loc_ready_out[1], exp_drops);
    end
    bus.up_ready_in = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      step();
      tests_run++;
      if (bus.up_valid_out !== 1'b1 || bus.up_data_out !== (16'h1100 | 16'(n))) begin
        tests_failed++;
        $display("FAIL fc_drain[%0d]: got v=%b d=%h expected 1/%h",
                 n, bus.up_valid_out, bus.up_data_out, 16'h1100 | 16'(n));
      end
    end
    step();
    tests_run++;
    if (bus.up_valid_out !== 1'b0 || bus.loc_ready_out[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL fc_empty: got v=%b rdy=%b expected 0/1", bus.up_valid_out, bus.loc_ready_out[1]);
    end
  endtask

  task automatic test_misroute();
    bus.up_data_in  = 16'h2000;
    bus.up_valid_in = 1'b1;
    tests_run++;
    if (bus.up_ready_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL misroute_ready: got %b expected 1", bus.up_ready_out);
    end
    step();
    bus.up_valid_in = 1'b0;
    exp_drops++;
    tests_run++;
    if (bus.drop_count !== 8'(exp_drops)) begin
      tests_failed++;
      $display("FAIL misroute_drop: got %0d expected %0d", bus.drop_count, exp_drops);
    end
    step();
    step();
    tests_run++;
    if (bus.loc_valid_out !== 4'h0 || bus.up_valid_out !== 1'b0 || bus.up_ready_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL misroute_quiet: got loc=%h up=%b urdy=%b expected 0/0/1",
               bus.loc_valid_out, bus.up_valid_out, bus.up_ready_out);
    end
    bus.up_data_in  = 16'h2ABC;
    bus.up_valid_in = 1'b1;
    for (int n = 0; n < 300; n++) step();
    bus.up_valid_in = 1'b0;
    exp_drops = (exp_drops + 300 > 255) ? 255 : exp_drops + 300;
    tests_run++;
    if (bus.drop_count !== 8'(exp_drops)) begin
      tests_failed++;
      $display("FAIL misroute_saturate: got %0d expected %0d", bus.drop_count, exp_drops);
    end
  endtask

  task automatic test_reset_midtraffic();
    bus.up_ready_in = 1'b0;
    for (int n = 0; n < 4; n++) begin
      bus.loc_data_in[31:16] = 16'h1200 | 16'(n);
      bus.loc_data_in[47:32] = 16'h6000 | 16'(n);
      bus.loc_valid_in = 4'b0110;
      step();
    end
    bus.loc_valid_in = 4'b0000;
    reset = 1'b1;
    #1;
    tests_run++;
    if (bus.up_valid_out !== 1'b0 || bus.loc_valid_out !== 4'h0 || bus.drop_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_async: got up=%b loc=%h drop=%0d expected 0/0/0",
               bus.up_valid_out, bus.loc_valid_out, bus.drop_count);
    end
    step();
    step();
    reset = 1'b0;
    exp_drops = 0;
    step();
    tests_run++;
    if (bus.loc_ready_out !== 4'hF || bus.up_ready_out !== 1'b1 || bus.drop_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_release: got lrdy=%h urdy=%b drop=%0d expected f/1/0",
               bus.loc_ready_out, bus.up_ready_out, bus.drop_count);
    end
    bus.up_ready_in = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step();
      tests_run++;
      if (bus.up_valid_out !== 1'b0 || bus.loc_valid_out !== 4'h0) begin
        tests_failed++;
        $display("FAIL reset_stale[%0d]: got up=%b loc=%h expected 0/0", n, bus.up_valid_out, bus.loc_valid_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_local_route();
    test_uplink_backpressure();
    test_contention();
    test_flow_control();
    test_misroute();
    test_reset_midtraffic();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
